// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns PC/IR, times instruction memory reads, flags illegal fetches.
// Optional FETCH_ALIGN_CHECK_EN: treat PC[1:0] != 0 as an illegal fetch.
module instr_fetch_ctrl #(
  parameter int unsigned MEM_BYTES   = 256,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        FetchReq,
  input  logic        PCWrite,
  input  logic [31:0] PCIn,
  output logic [31:0] A,
  output logic        InstrMemRW,
  input  logic [31:0] RD,
  output logic [31:0] IR,
  output logic [31:0] PC,
  output logic        FetchDone,
  output logic        FetchBusy,
  output logic        Fault
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_FAULT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  logic [31:0] eff_pc;
  logic [32:0] last_ok;
  logic        illegal;

  // A same-cycle PCWrite in IDLE redirects the fetch, so legality is judged on PCIn.
  assign eff_pc  = PCWrite ? PCIn : pc_q;
  // 33-bit compare keeps PCs near 2^32 from wrapping into the legal window.
  assign last_ok = 33'(MEM_BYTES) - 33'd4;
`ifdef FETCH_ALIGN_CHECK_EN
  assign illegal = ({1'b0, eff_pc} > last_ok) || (eff_pc[1:0] != 2'b00);
`else
  assign illegal = ({1'b0, eff_pc} > last_ok);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (PCWrite) pc_d = PCIn;
        if (FetchReq) begin
          if (illegal) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          ir_d    = RD;
          pc_d    = pc_q + 32'd4;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (PCWrite) pc_d = PCIn;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (PCWrite) begin
          pc_d    = PCIn;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign A          = pc_q;
  assign PC         = pc_q;
  assign IR         = ir_q;
  assign InstrMemRW = (state_q == S_ACCESS);
  assign FetchDone  = (state_q == S_DONE);
  assign FetchBusy  = (state_q == S_ACCESS) || (state_q == S_DONE);
  assign Fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: two instances (WAIT_CYCLES 1 and 3) run in lockstep against a timeline model.
module tb_instr_fetch_ctrl;
  localparam int MB = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, fr, pw;
  logic [31:0] pin;
  logic [7:0]  mem [256];

  logic [31:0] a0, ir0, pc0, rd0, a1, ir1, pc1, rd1;
  logic        rw0, dn0, bz0, ft0, rw1, dn1, bz1, ft1;

  assign rd0 = {mem[a0[7:0]], mem[8'(a0[7:0] + 8'd1)], mem[8'(a0[7:0] + 8'd2)], mem[8'(a0[7:0] + 8'd3)]};
  assign rd1 = {mem[a1[7:0]], mem[8'(a1[7:0] + 8'd1)], mem[8'(a1[7:0] + 8'd2)], mem[8'(a1[7:0] + 8'd3)]};

  instr_fetch_ctrl #(.MEM_BYTES(MB), .RESET_PC(32'h0), .WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .FetchReq(fr), .PCWrite(pw), .PCIn(pin), .A(a0), .InstrMemRW(rw0),
    .RD(rd0), .IR(ir0), .PC(pc0), .FetchDone(dn0), .FetchBusy(bz0), .Fault(ft0));
  instr_fetch_ctrl #(.MEM_BYTES(MB), .RESET_PC(32'h0), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .FetchReq(fr), .PCWrite(pw), .PCIn(pin), .A(a1), .InstrMemRW(rw1),
    .RD(rd1), .IR(ir1), .PC(pc1), .FetchDone(dn1), .FetchBusy(bz1), .Fault(ft1));

  // Model: per instance, cycles left in the current fetch (W access cycles then one done cycle).
  int          wc   [2] = '{1, 3};
  logic [31:0] m_pc [2];
  logic [31:0] m_ir [2];
  int          m_left [2];
  bit          m_flt  [2];
  int          nchk = 0, npass = 0;

  function automatic logic [31:0] word(input logic [31:0] ad);
    return {mem[ad[7:0]], mem[8'(ad[7:0] + 8'd1)], mem[8'(ad[7:0] + 8'd2)], mem[8'(ad[7:0] + 8'd3)]};
  endfunction

  function automatic bit illegal(input logic [31:0] p);
    bit bad;
    bad = (64'(p) + 64'd3) >= 64'(MB);
`ifdef FETCH_ALIGN_CHECK_EN
    bad = bad || (p % 4 != 0);
`endif
    return bad;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_ir[k] = 32'h0; m_left[k] = 0; m_flt[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int k);
    if (m_flt[k]) begin
      if (pw) begin m_pc[k] = pin; m_flt[k] = 1'b0; end
    end else if (m_left[k] == 0) begin
      logic [31:0] target;
      target = pw ? pin : m_pc[k];
      m_pc[k] = target;
      if (fr) begin
        if (illegal(target)) m_flt[k] = 1'b1;
        else m_left[k] = wc[k] + 1;
      end
    end else if (m_left[k] == 1) begin
      if (pw) m_pc[k] = pin;
      m_left[k] = 0;
    end else begin
      if (m_left[k] == 2) begin
        m_ir[k] = word(m_pc[k]);
        m_pc[k] = m_pc[k] + 32'd4;
      end
      m_left[k] = m_left[k] - 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("u0.A",    a0,  m_pc[0]);
    check("u0.PC",   pc0, m_pc[0]);
    check("u0.IR",   ir0, m_ir[0]);
    check("u0.RW",   32'(rw0), 32'(m_left[0] >= 2));
    check("u0.Done", 32'(dn0), 32'(m_left[0] == 1));
    check("u0.Busy", 32'(bz0), 32'(m_left[0] >= 1));
    check("u0.Flt",  32'(ft0), 32'(m_flt[0]));
    check("u1.A",    a1,  m_pc[1]);
    check("u1.PC",   pc1, m_pc[1]);
    check("u1.IR",   ir1, m_ir[1]);
    check("u1.RW",   32'(rw1), 32'(m_left[1] >= 2));
    check("u1.Done", 32'(dn1), 32'(m_left[1] == 1));
    check("u1.Busy", 32'(bz1), 32'(m_left[1] >= 1));
    check("u1.Flt",  32'(ft1), 32'(m_flt[1]));
  endtask

  task automatic step(input bit f, input bit w, input logic [31:0] p);
    fr = f; pw = w; pin = p;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  // Asynchronous reset pulse taken mid-cycle, away from the clock edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ir_hold, p;
    int          pulses;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    {mem[0], mem[1], mem[2], mem[3]}     = {8'h20, 8'h08, 8'h00, 8'h05};
    {mem[4], mem[5]}                     = {8'hab, 8'hcd};
    {mem[16], mem[17], mem[18], mem[19]} = {8'h8c, 8'h09, 8'h00, 8'h10};
    fr = 1'b0; pw = 1'b0; pin = 32'h0;
    rst_n = 1'b0;
    #1 model_reset();
    check_all();
    #12 rst_n = 1'b1;

    // Single fetch from reset: one access cycle at A=0 on u0, then capture.
    step(1'b1, 1'b0, 32'h0);
    check("t1.A_access", a0, 32'h0);
    check("t1.RW_access", 32'(rw0), 32'd1);
    step(1'b0, 1'b0, 32'h0);
    check("t1.IR", ir0, 32'h2008_0005);
    check("t1.PC", pc0, 32'h4);
    check("t1.RW_off", 32'(rw0), 32'd0);
    idle(4);

    // FetchReq held: u1 (3 wait cycles) completes a fetch every 5 cycles.
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (dn1) pulses++;
    end
    check("t2.done_pulses", 32'(pulses), 32'd3);
    idle(5);

    // PCWrite and FetchReq together: fetch uses PCIn.
    pulse_reset();
    step(1'b1, 1'b1, 32'h10);
    check("t3.A", a0, 32'h10);
    idle(5);
    check("t3.IR", ir0, 32'h8c09_0010);
    check("t3.PC", pc0, 32'h14);

    // Last legal word, then out-of-range fault and recovery.
    step(1'b0, 1'b1, 32'd252);
    step(1'b1, 1'b0, 32'h0);
    idle(4);
    check("t4.PC256", pc0, 32'd256);
    ir_hold = ir0;
    step(1'b1, 1'b0, 32'h0);
    check("t4.Fault", 32'(ft0), 32'd1);
    check("t4.RW0", 32'(rw0), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    check("t4.IRhold", ir0, ir_hold);
    step(1'b0, 1'b1, 32'h0);
    check("t4.cleared", 32'(ft0), 32'd0);

    // Unaligned PC.
    step(1'b0, 1'b1, 32'h2);
    step(1'b1, 1'b0, 32'h0);
    idle(5);
`ifdef FETCH_ALIGN_CHECK_EN
    check("t5.Fault", 32'(ft0), 32'd1);
`else
    check("t5.IR", ir0, 32'h0005_abcd);
    check("t5.PC", pc0, 32'h6);
`endif
    step(1'b0, 1'b1, 32'h0);
    idle(2);

    // Random traffic, including huge and unaligned targets.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: p = 32'($urandom_range(0, 63)) * 4;
        1: p = 32'($urandom_range(0, 259));
        2: p = $urandom;
        default: p = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      endcase
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), p);
    end
    step(1'b0, 1'b1, 32'h0);
    idle(5);

    // Reset mid-ACCESS on u1: no FetchDone afterwards.
    step(1'b1, 1'b0, 32'h20);
    step(1'b0, 1'b0, 32'h0);
    check("t6.in_access", 32'(rw1), 32'd1);
    pulse_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (dn0 || dn1) pulses++;
    end
    check("t6.no_done", 32'(pulses), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch sequencer for the multi-cycle CPU's instruction memory. Owns the program counter and instruction register. On a request from the main control unit it drives the instruction memory's byte address and read enable for a programmable number of access cycles, then captures the 32-bit big-endian word into IR and advances PC by 4. It also applies branch/jump PC loads and flags out-of-range (and optionally misaligned) fetches instead of issuing them.

## Interface
- MEM_BYTES, 256: instruction memory size in bytes; a fetch is legal only if PC+3 < MEM_BYTES.
- RESET_PC, 32'h0000_0000: PC value after reset.
- WAIT_CYCLES, 1: cycles InstrMemRW is held before IR capture; legal range 1..15.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- FetchReq  input  1  start fetch at current PC; sampled only in IDLE.
- PCWrite  input  1  load PC from PCIn; accepted in IDLE, DONE, FAULT; ignored in ACCESS.
- PCIn  input  32  branch/jump target.
- A  output  32  instruction memory byte address; always equals PC.
- InstrMemRW  output  1  instruction memory read enable; high only in ACCESS.
- RD  input  32  instruction memory read data (combinational from A).
- IR  output  32  registered instruction.
- PC  output  32  registered program counter.
- FetchDone  output  1  one-cycle pulse in DONE; IR holds the new instruction.
- FetchBusy  output  1  high in ACCESS and DONE.
- Fault  output  1  high while in FAULT.

## Operation
- States: IDLE, ACCESS, DONE, FAULT; 4-bit wait counter.
- IDLE:
  - PCWrite loads PC from PCIn.
  - FetchReq checks the effective PC (PCIn if PCWrite is also high, else PC).
  - Legal PC: go to ACCESS and set counter = WAIT_CYCLES-1.
  - Illegal PC: go to FAULT.
- ACCESS:
  - InstrMemRW=1.
  - Counter decrements each cycle.
  - In the cycle the counter reads 0: IR<=RD, PC<=PC+4 (mod 2^32), then go to DONE.
  - FetchReq and PCWrite are ignored.
- DONE:
  - FetchDone=1 for exactly one cycle, then IDLE.
  - PCWrite here overrides the PC+4 value.
  - FetchReq here is ignored; it must be held or reissued in IDLE.
- FAULT:
  - Fault=1, InstrMemRW=0; IR and PC hold.
  - Stays in FAULT until PCWrite, which loads PC and moves to IDLE.
  - FetchReq is ignored.
- Range check: fault when PC > MEM_BYTES-4, computed in 33 bits so PC near 2^32 does not wrap to legal.
- Simultaneous PCWrite+FetchReq in IDLE: PC loads first; the fetch uses PCIn, including the legality check.

## Timing
- Reset values (asynchronous on rst_n low): state=IDLE, PC=RESET_PC, A=RESET_PC, IR=0, InstrMemRW=0, FetchDone=0, FetchBusy=0, Fault=0, counter=0.
- Reset asserted in any state aborts immediately; no IR/PC update occurs for the aborted fetch.
- Latency: FetchReq high at edge N (IDLE) gives the following:
  - InstrMemRW high in cycles N+1..N+WAIT_CYCLES.
  - IR/PC update at edge N+WAIT_CYCLES+1.
  - FetchDone high in cycle N+WAIT_CYCLES+1.
- Minimum fetch period: WAIT_CYCLES+2 cycles.
- Fault: asserted the cycle after the offending FetchReq edge; InstrMemRW never rises for a faulting fetch.
- All outputs are registered, or decoded from state only; no combinational path from inputs to outputs.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: a fetch with PC[1:0]≠0 is also illegal and goes to FAULT, same rules as range fault.
- Undefined: unaligned PCs are fetched normally. The memory returns bytes PC..PC+3 big-endian; only the range check applies.

## Test plan
- Reset then FetchReq pulse, WAIT_CYCLES=1, memory bytes 0..3 = 20 08 00 05:
  - InstrMemRW high exactly 1 cycle with A=0.
  - Next cycle IR=32'h20080005, PC=4, FetchDone single pulse.
- WAIT_CYCLES=3, FetchReq held high continuously:
  - InstrMemRW high 3 cycles per fetch.
  - FetchDone pulses every 5 cycles.
  - PC steps 0→4→8.
- PCWrite=1, PCIn=32'h10, FetchReq=1 in the same IDLE cycle: first access uses A=32'h10; after capture IR=word at bytes 16..19 and PC=32'h14.
- PCIn=252 then fetch: legal, PC becomes 256. Next FetchReq: Fault=1, InstrMemRW stays 0, IR unchanged. PCWrite to 0 clears Fault and returns to IDLE.
- PC=2 fetch:
  - With FETCH_ALIGN_CHECK_EN: Fault=1.
  - Without it: IR={mem[2],mem[3],mem[4],mem[5]} and PC=6.
- rst_n dropped mid-ACCESS: all outputs return to reset values immediately, and no FetchDone follows.
